// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the cache-to-AXI arbiter.
// Build option: AXI_ARB_RR_EN (see axi_arb_grant).
package axi_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned ID_W   = 4;

  localparam logic [ID_W-1:0] IC_ID = 4'd0;
  localparam logic [ID_W-1:0] DC_ID = 4'd1;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [7:0] LEN_2BEAT  = 8'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B
  } state_e;

  typedef enum logic [1:0] {
    OWN_IC,
    OWN_DC_RD,
    OWN_DC_WR
  } owner_e;

  // Clear the byte offset so every request starts on a 16-byte block.
  function automatic logic [ADDR_W-1:0] blk_align(input logic [ADDR_W-1:0] a);
    return a & 32'hFFFF_FFF0;
  endfunction

  // AXI transaction ID carried by each owner.
  function automatic logic [ID_W-1:0] owner_id(input owner_e o);
    return (o == OWN_IC) ? IC_ID : DC_ID;
  endfunction

endpackage

// File: rtl/axi_cache_arbiter_if.sv
// AXI4 memory-port signal bundle between the arbiter (master) and memory (slave).
interface axi_cache_arbiter_if;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );

endinterface

// File: rtl/axi_arb_grant.sv
// Request selection for the cache arbiter.
// AXI_ARB_RR_EN defined: dcache and icache reads alternate round-robin;
// otherwise dcache reads always beat icache reads. Write-back always wins.
module axi_arb_grant
  import axi_arb_pkg::*;
(
`ifdef AXI_ARB_RR_EN
  input  logic   clock,
  input  logic   rst_n,
  input  logic   i_idle,
`endif
  input  logic   i_dc_wr_req,
  input  logic   i_dc_rd_req,
  input  logic   i_ic_rd_req,
  output logic   o_valid_c,
  output owner_e o_owner_c
);

  logic w_dc_first;

`ifdef AXI_ARB_RR_EN
  logic r_last_dc;

  assign w_dc_first = ~r_last_dc;

  // Remember which cache took the most recent read grant; starts as icache.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_last_dc <= 1'b0;
    end else if (i_idle && o_valid_c && (o_owner_c != OWN_DC_WR)) begin
      r_last_dc <= (o_owner_c == OWN_DC_RD);
    end
  end
`else
  assign w_dc_first = 1'b1;
`endif

  // Write-back first, then reads ordered by w_dc_first.
  always_comb begin
    o_valid_c = i_dc_wr_req | i_dc_rd_req | i_ic_rd_req;
    o_owner_c = OWN_IC;
    if (i_dc_wr_req) begin
      o_owner_c = OWN_DC_WR;
    end else if (i_dc_rd_req && (!i_ic_rd_req || w_dc_first)) begin
      o_owner_c = OWN_DC_RD;
    end
  end

endmodule

// File: rtl/axi_cache_arbiter.sv
// Shares one AXI4 port between icache refills and dcache refills/write-backs.
// Each cache block becomes a single 2-beat 64-bit INCR burst; one transaction
// is in flight at a time. Build option: AXI_ARB_RR_EN (round-robin reads).
module axi_cache_arbiter
  import axi_arb_pkg::*;
(
  input  logic                clock,
  input  logic                rst_n,
  input  logic                ic_rd_req,
  input  logic [ADDR_W-1:0]   ic_rd_addr,
  output logic                ic_rd_ack,
  input  logic                dc_rd_req,
  input  logic [ADDR_W-1:0]   dc_rd_addr,
  output logic                dc_rd_ack,
  input  logic                dc_wr_req,
  input  logic [ADDR_W-1:0]   dc_wr_addr,
  input  logic [BLK_W-1:0]    dc_wr_data,
  output logic                dc_wr_done,
  output logic [DATA_W-1:0]   rd_data,
  output logic                ic_rd_valid,
  output logic                dc_rd_valid,
  output logic                rd_last,
  axi_cache_arbiter_if.master axi
);

  state_e              r_state;
  owner_e              r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic [ID_W-1:0]     r_id;
  logic [BLK_W-1:0]    r_blk;
  logic                r_cnt;
  logic                r_arvalid;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_rready;
  logic                r_bready;

  logic                w_gnt_valid;
  owner_e              w_gnt_owner;
  logic [ADDR_W-1:0]   w_gnt_addr;
  logic                w_r_beat;
  logic                w_unused;

  axi_arb_grant u_grant (
`ifdef AXI_ARB_RR_EN
    .clock       (clock),
    .rst_n       (rst_n),
    .i_idle      (r_state == ST_IDLE),
`endif
    .i_dc_wr_req (dc_wr_req),
    .i_dc_rd_req (dc_rd_req),
    .i_ic_rd_req (ic_rd_req),
    .o_valid_c   (w_gnt_valid),
    .o_owner_c   (w_gnt_owner)
  );

  // Address of whichever request wins this cycle.
  always_comb begin
    w_gnt_addr = ic_rd_addr;
    case (w_gnt_owner)
      OWN_DC_WR: w_gnt_addr = dc_wr_addr;
      OWN_DC_RD: w_gnt_addr = dc_rd_addr;
      default:   w_gnt_addr = ic_rd_addr;
    endcase
  end

  // Transaction sequencer: grant, address phase, data phase, response.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWN_IC;
      r_addr    <= '0;
      r_id      <= '0;
      r_blk     <= '0;
      r_cnt     <= 1'b0;
      r_arvalid <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_rready  <= 1'b0;
      r_bready  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_owner <= w_gnt_owner;
            r_addr  <= blk_align(w_gnt_addr);
            r_id    <= owner_id(w_gnt_owner);
            if (w_gnt_owner == OWN_DC_WR) begin
              r_blk     <= dc_wr_data;
              r_awvalid <= 1'b1;
              r_state   <= ST_AW;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_AR;
            end
          end
        end
        ST_AR: begin
          if (axi.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_R;
          end
        end
        ST_R: begin
          if (axi.rvalid && axi.rlast) begin
            r_rready <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        ST_AW: begin
          if (axi.awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_cnt     <= 1'b0;
            r_state   <= ST_W;
          end
        end
        ST_W: begin
          if (axi.wready) begin
            if (r_cnt) begin
              r_wvalid <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= ST_B;
            end else begin
              r_cnt <= 1'b1;
            end
          end
        end
        ST_B: begin
          if (axi.bvalid) begin
            r_bready <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // AXI request channels driven from the latched transaction.
  assign axi.arvalid = r_arvalid;
  assign axi.araddr  = r_addr;
  assign axi.arid    = r_id;
  assign axi.arlen   = LEN_2BEAT;
  assign axi.arsize  = SIZE_8B;
  assign axi.arburst = BURST_INCR;
  assign axi.awvalid = r_awvalid;
  assign axi.awaddr  = r_addr;
  assign axi.awid    = r_id;
  assign axi.awlen   = LEN_2BEAT;
  assign axi.awsize  = SIZE_8B;
  assign axi.awburst = BURST_INCR;
  assign axi.wvalid  = r_wvalid;
  assign axi.wdata   = !r_wvalid ? '0 : (r_cnt ? r_blk[127:64] : r_blk[63:0]);
  assign axi.wstrb   = r_wvalid ? 8'hff : 8'h00;
  assign axi.wlast   = r_wvalid & r_cnt;
  assign axi.rready  = r_rready;
  assign axi.bready  = r_bready;

  // Handshake pulses and read beats back to the caches; suppressed in reset.
  assign w_r_beat    = rst_n & r_rready & axi.rvalid;
  assign ic_rd_ack   = rst_n & r_arvalid & axi.arready & (r_owner == OWN_IC);
  assign dc_rd_ack   = rst_n & r_arvalid & axi.arready & (r_owner == OWN_DC_RD);
  assign dc_wr_done  = rst_n & r_bready & axi.bvalid;
  assign ic_rd_valid = w_r_beat & (r_owner == OWN_IC);
  assign dc_rd_valid = w_r_beat & (r_owner == OWN_DC_RD);
  assign rd_last     = w_r_beat & axi.rlast;
  assign rd_data     = r_rready ? axi.rdata : '0;

  // Response ID/status fields carry nothing the caches need.
  assign w_unused = ^{axi.rresp, axi.rid, axi.bresp, axi.bid};

endmodule

// File: doc/axi_cache_arbiter.md
# axi_cache_arbiter
Arbiter and sequencer that shares the single AXI4 memory port between the instruction cache (block refill only) and the data cache (block refill and write-back). It sits between both caches and the simulated SRAM/SDRAM slave and converts each 16-byte cache-block request into one 2-beat, 64-bit INCR burst. Exactly one transaction is outstanding at any time.
## Interface
- IC_ID, 4'd0, arid driven for icache reads
- DC_ID, 4'd1, arid/awid driven for dcache transactions
- clock  in  1  clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- ic_rd_req  in  1  icache refill request; held until ic_rd_ack
- ic_rd_addr  in  32  icache refill address; bits [3:0] ignored
- ic_rd_ack  out  1  1-cycle pulse on AR handshake for icache
- dc_rd_req  in  1  dcache refill request; held until dc_rd_ack
- dc_rd_addr  in  32  dcache refill address; bits [3:0] ignored
- dc_rd_ack  out  1  1-cycle pulse on AR handshake for dcache
- dc_wr_req  in  1  dcache write-back request; held until dc_wr_done
- dc_wr_addr  in  32  write-back address; bits [3:0] ignored
- dc_wr_data  in  128  write-back block; [63:0] is beat 0
- dc_wr_done  out  1  1-cycle pulse on B handshake
- rd_data  out  64  read beat data; rdata passed through combinationally
- ic_rd_valid / dc_rd_valid  out  1 each  read beat valid for the owning cache
- rd_last  out  1  final beat of the block
- AR master: arvalid out 1, arready in 1, araddr out 32, arid out 4, arlen out 8, arsize out 3, arburst out 2
- R master: rvalid in 1, rready out 1, rdata in 64, rresp in 2, rid in 4, rlast in 1
- AW master: awvalid out 1, awready in 1, awaddr out 32, awid out 4, awlen out 8, awsize out 3, awburst out 2
- W master: wvalid out 1, wready in 1, wdata out 64, wstrb out 8, wlast out 1
- B master: bvalid in 1, bready out 1, bresp in 2, bid in 4
## Operation
- FSM states: IDLE, AR, R, AW, W, B.
- IDLE: grant selection each cycle. dc_wr_req has highest priority, then dc_rd_req, then ic_rd_req. Grant latches the owner and the address {addr[31:4],4'h0}; the next state is AW for a write or AR for a read.
- AR: arvalid=1 with the latched address, arlen=8'd1, arsize=3'b011, arburst=2'b01, and arid=owner ID. On arvalid&&arready, pulse the owner's ack and move to R.
- R: rready=1. Each rvalid cycle asserts the owner's *_rd_valid, with rd_data=rdata and rd_last=rlast. On rvalid&&rlast, move to IDLE. rid and rresp are not checked.
- AW: awvalid=1 with the same len/size/burst values and awid=DC_ID. On handshake, move to W with beat counter=0.
- W: wvalid=1, wstrb=8'hff, wdata=dc_wr_data[64*cnt+:64], wlast=(cnt==1). dc_wr_data is latched at grant. Each wvalid&&wready increments cnt. A handshake with wlast moves to B.
- B: bready=1. On bvalid, pulse dc_wr_done and move to IDLE. bresp is ignored.
- Requests that arrive while busy wait. Requests are never queued beyond the held req lines.
## Timing
- Reset values: every valid, ready, ack, done and last output is 0. Addresses, IDs and data are 0. State is IDLE.
- Request seen in IDLE at cycle N: grant at N, arvalid/awvalid high at N+1.
- Fastest read with a zero-wait slave: req at N, ack at N+1, beats at N+2 and N+3, IDLE at N+4, next grant at N+4.
- Fastest write: grant at N, AW at N+1, W beats at N+2 and N+3, B at N+4, done at N+4.
- Simultaneous requests are resolved by priority. The losing request stays pending and is served on a later return to IDLE.
- Address changes after grant are ignored. Dropping req before ack is illegal.
- Reset mid-transaction aborts to IDLE with no ack or done pulse.
## Configuration
- AXI_ARB_RR_EN defined: dc_rd_req and ic_rd_req alternate round-robin. A last-read-owner flag flips on each read grant and resets to "icache last". Writes stay highest priority.
- Undefined: fixed priority as in Operation; dcache reads always win over icache reads.
## Structure
- Package axi_arb_pkg holds the following:
  - state enum
  - BURST_INCR=2'b01, SIZE_8B=3'b011, LEN_2BEAT=8'd1
  - owner enum {OWN_IC, OWN_DC_RD, OWN_DC_WR}
- Sub-module axi_arb_grant: combinational priority/round-robin selection plus the RR flag register.
## Test plan
- icache read at 0x8000_0014, zero-wait slave -> araddr=0x8000_0010, arid=0, arlen=1; ic_rd_ack at N+1; two ic_rd_valid beats, rd_last on the second.
- dcache write at 0x8000_0020 with data {0x2222…, 0x1111…} -> beat0 wdata=0x1111…, beat1 wdata=0x2222… with wlast, wstrb=0xff; dc_wr_done on bvalid.
- dc_wr_req, dc_rd_req and ic_rd_req all asserted in the same cycle -> service order is write, dcache read, icache read in the fixed build; with AXI_ARB_RR_EN, the reads follow RR order.
- Slave with arready low for 3 cycles and rvalid gaps -> arvalid held stable, no ack until handshake, rd_valid only on rvalid cycles.
- Slave with wready low for 2 cycles on beat 1 -> wdata and wlast held stable, counter does not advance.
- rst_n low during the R state -> all outputs reach reset values next cycle; a later request completes normally.
